// File: rtl/move_pkg.sv
// Shared types and helpers for the move command generator.
// dir_t / mstate_t enums, priority pick and direction-to-mask helpers.
package move_pkg;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } mstate_t;

    // deb bit order: [0]=up [1]=down [2]=left [3]=right
    function automatic dir_t prio_pick(logic [3:0] deb);
        dir_t d;
        d = DIR_NONE;
        if (deb[0]) begin
            d = DIR_UP;
        end else if (deb[1]) begin
            d = DIR_DOWN;
        end else if (deb[2]) begin
            d = DIR_LEFT;
        end else if (deb[3]) begin
            d = DIR_RIGHT;
        end
        return d;
    endfunction

    function automatic logic [3:0] dir_mask(dir_t d);
        logic [3:0] m;
        m = 4'b0000;
        case (d)
            DIR_UP:    m = 4'b0001;
            DIR_DOWN:  m = 4'b0010;
            DIR_LEFT:  m = 4'b0100;
            DIR_RIGHT: m = 4'b1000;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/move_cmd_gen_if.sv
// Button/enable inputs and move pulse outputs of one player's generator.
// master: drives buttons and enable; slave: the generator, drives move_*.
interface move_cmd_gen_if;

    logic btn_up;
    logic btn_down;
    logic btn_left;
    logic btn_right;
    logic enable;
    logic move_up;
    logic move_down;
    logic move_left;
    logic move_right;

    modport master (
        output btn_up,
        output btn_down,
        output btn_left,
        output btn_right,
        output enable,
        input  move_up,
        input  move_down,
        input  move_left,
        input  move_right
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        input  btn_left,
        input  btn_right,
        input  enable,
        output move_up,
        output move_down,
        output move_left,
        output move_right
    );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability counter for one raw button.
// Ports: clk, rst (async, active-high), raw (async input), deb (debounced level).
module button_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    // Any cycle where the synced level agrees with deb restarts the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync_q[1] != deb_q) begin
            if (cnt_q == LAST) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/move_cmd_gen.sv
// Turns four raw buttons into one-cycle, mutually exclusive move pulses.
// Ports: clk, rst (async, active-high), bus (move_cmd_gen_if.slave).
// Macro AUTO_REPEAT_EN: when defined, a held button repeats after
// REPEAT_DELAY then every REPEAT_RATE cycles; otherwise one pulse per press.
module move_cmd_gen
    import move_pkg::*;
#(
    parameter int DB_CYCLES    = 16,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16
) (
    input  logic          clk,
    input  logic          rst,
    move_cmd_gen_if.slave bus
);

    // Out-of-range timing parameters keep the generator silent.
    localparam bit CFG_OK = (DB_CYCLES >= 1) &&
                            (REPEAT_DELAY >= 2) &&
                            (REPEAT_RATE >= 1);

    logic [3:0] raw;
    logic [3:0] deb;

    assign raw = {bus.btn_right, bus.btn_left,
                  bus.btn_down, bus.btn_up};

    for (genvar i = 0; i < 4; i++) begin : g_db
        button_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk(clk),
            .rst(rst),
            .raw(raw[i]),
            .deb(deb[i])
        );
    end

    mstate_t    state_q;
    mstate_t    state_d;
    dir_t       dir_q;
    dir_t       dir_d;
    logic       pulse;
    logic       held;
    logic [3:0] move_q;
    logic [3:0] move_d;

`ifdef AUTO_REPEAT_EN
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                          REPEAT_DELAY : REPEAT_RATE;
    localparam int TW = $clog2(TMAX);
    localparam logic [TW-1:0] T_DELAY = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] T_RATE  = TW'(REPEAT_RATE - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [TW-1:0] timer_inc;

    // Saturating increment: the timer parks at all-ones, never wraps.
    assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;
`endif

    // Only the latched button keeps a hold alive.
    assign held = |(deb & dir_mask(dir_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_NONE;
            move_q  <= 4'b0000;
`ifdef AUTO_REPEAT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            move_q  <= move_d;
`ifdef AUTO_REPEAT_EN
            timer_q <= timer_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pulse   = 1'b0;
`ifdef AUTO_REPEAT_EN
        timer_d = timer_q;
`endif
        unique case (state_q)
            IDLE: begin
                dir_d = DIR_NONE;
                if (bus.enable && CFG_OK && (|deb)) begin
                    dir_d   = prio_pick(deb);
                    pulse   = 1'b1;
                    state_d = HOLD;
`ifdef AUTO_REPEAT_EN
                    timer_d = '0;
`endif
                end
            end
            HOLD: begin
                if (!bus.enable || !held) begin
                    state_d = IDLE;
                    dir_d   = DIR_NONE;
`ifdef AUTO_REPEAT_EN
                    timer_d = '0;
                end else if (timer_q == T_DELAY) begin
                    pulse   = 1'b1;
                    timer_d = '0;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_inc;
`endif
                end
            end
`ifdef AUTO_REPEAT_EN
            REPEAT: begin
                if (!bus.enable || !held) begin
                    state_d = IDLE;
                    dir_d   = DIR_NONE;
                    timer_d = '0;
                end else if (timer_q == T_RATE) begin
                    pulse   = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                dir_d   = DIR_NONE;
            end
        endcase
    end

    // dir_d carries the direction being pulsed on press and repeat alike.
    always_comb begin
        move_d = 4'b0000;
        if (pulse) begin
            move_d = dir_mask(dir_d);
        end
    end

    assign bus.move_up    = move_q[0];
    assign bus.move_down  = move_q[1];
    assign bus.move_left  = move_q[2];
    assign bus.move_right = move_q[3];

endmodule
